// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues byte/half/word accesses on a single-outstanding
// req/ack bus, stalls the pipeline while in flight and registers the write-back triple.
module mem_lsu #(
    parameter int BUS_W          = 32,
    parameter bit ADDR_LSB_CHECK = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [4:0]       mem_wd,
    input  logic             mem_wreg,
    input  logic [BUS_W-1:0] mem_wdata,
    input  logic [3:0]       mem_op,
    input  logic [BUS_W-1:0] mem_addr,
    input  logic [BUS_W-1:0] mem_sdata,
    output logic             bus_req,
    output logic             bus_we,
    output logic [3:0]       bus_sel,
    output logic [BUS_W-1:0] bus_addr,
    output logic [BUS_W-1:0] bus_wdata,
    input  logic [BUS_W-1:0] bus_rdata,
    input  logic             bus_ack,
    output logic             stall_req,
    output logic             align_err,
    output logic [4:0]       wb_wd,
    output logic             wb_wreg,
    output logic [BUS_W-1:0] wb_wdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t     state;
    size_t      acc_size, size_q;
    logic       is_load, is_store, is_mem, ld_signed, misaligned, valid_mem;
    logic [1:0] off;
    logic [3:0] sel;
    logic [31:0] wdata_rep;

    logic       load_q, signed_q;
    logic [1:0] off_q;
    logic [31:0] load_data, ext_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ld_signed = 1'b0;
        acc_size  = SZ_WORD;
        case (mem_op)
            4'd1: begin is_load  = 1'b1; acc_size = SZ_BYTE; ld_signed = 1'b1; end
            4'd2: begin is_load  = 1'b1; acc_size = SZ_BYTE; end
            4'd3: begin is_load  = 1'b1; acc_size = SZ_HALF; ld_signed = 1'b1; end
            4'd4: begin is_load  = 1'b1; acc_size = SZ_HALF; end
            4'd5: begin is_load  = 1'b1; acc_size = SZ_WORD; end
            4'd6: begin is_store = 1'b1; acc_size = SZ_BYTE; end
            4'd7: begin is_store = 1'b1; acc_size = SZ_HALF; end
            4'd8: begin is_store = 1'b1; acc_size = SZ_WORD; end
            default: ;
        endcase
        is_mem     = is_load | is_store;
        misaligned = ADDR_LSB_CHECK && is_mem &&
                     (((acc_size == SZ_HALF) && mem_addr[0]) ||
                      ((acc_size == SZ_WORD) && (mem_addr[1:0] != 2'b00)));
        valid_mem  = is_mem && !misaligned;

        // Without the alignment trap the offending low bits are simply ignored.
        off = mem_addr[1:0];
        if (acc_size == SZ_HALF) off[0] = 1'b0;
        if (acc_size == SZ_WORD) off    = 2'b00;

        sel       = 4'b1111;
        wdata_rep = mem_sdata;
        case (acc_size)
            SZ_BYTE: begin
                sel       = 4'b1000 >> off;
                wdata_rep = {4{mem_sdata[7:0]}};
            end
            SZ_HALF: begin
                sel       = off[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{mem_sdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Big-endian lane pick and extension of the returned word.
    always_comb begin
        case (off_q)
            2'd0:    lane_b = bus_rdata[31:24];
            2'd1:    lane_b = bus_rdata[23:16];
            2'd2:    lane_b = bus_rdata[15:8];
            default: lane_b = bus_rdata[7:0];
        endcase
        lane_h = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        case (size_q)
            SZ_BYTE: ext_data = {{24{signed_q & lane_b[7]}}, lane_b};
            SZ_HALF: ext_data = {{16{signed_q & lane_h[15]}}, lane_h};
            default: ext_data = bus_rdata;
        endcase
    end

    always_comb begin
        stall_req = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall_req = valid_mem && !flush;
                REQ:     stall_req = 1'b1;
                DRAIN:   stall_req = is_mem && !flush;
                default: stall_req = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= 4'b0000;
            bus_addr  <= '0;
            bus_wdata <= '0;
            wb_wd     <= 5'd0;
            wb_wreg   <= 1'b0;
            wb_wdata  <= '0;
            align_err <= 1'b0;
            load_q    <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= SZ_WORD;
            off_q     <= 2'b00;
            load_data <= '0;
        end else begin
            align_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_mem && !flush) begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_sel   <= sel;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_wdata <= wdata_rep;
                        load_q    <= is_load;
                        signed_q  <= ld_signed;
                        size_q    <= acc_size;
                        off_q     <= off;
                        wb_wreg   <= 1'b0;
                        state     <= REQ;
                    end else begin
                        wb_wd     <= mem_wd;
                        wb_wdata  <= mem_wdata;
                        wb_wreg   <= mem_wreg && !flush && !misaligned;
                        align_err <= misaligned && !flush;
                    end
                end
                REQ: begin
                    wb_wreg <= 1'b0;
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        load_data <= ext_data;
                        state     <= flush ? IDLE : DONE;
                    end else if (flush) begin
                        // A request cannot be withdrawn; wait out the ack.
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    wb_wd    <= mem_wd;
                    wb_wdata <= load_data;
                    wb_wreg  <= mem_wreg && load_q && !flush;
                    state    <= IDLE;
                end
                DRAIN: begin
                    wb_wreg <= 1'b0;
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu: each scenario task drives the EX/MEM
// inputs and plays the bus responder by hand, comparing against hand-computed values.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_req;
    logic        align_err;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_lsu #(.BUS_W(32), .ADDR_LSB_CHECK(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_sdata (mem_sdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall_req (stall_req),
        .align_err (align_err),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        mem_op    = 4'd0;
        mem_wd    = 5'd0;
        mem_wreg  = 1'b0;
        mem_wdata = 32'h0;
        mem_addr  = 32'h0;
        mem_sdata = 32'h0;
        bus_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus_rdata = 32'h0;
        mem_op    = 4'd5;
        tick();
        tick();
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we: got %b want 0", bus_we); end
        n_checks++; if (bus_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_bus_sel: got %b want 0000", bus_sel); end
        n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus_wdata: got %h want 0", bus_wdata); end
        n_checks++; if (wb_wd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_wd: got %0d want 0", wb_wd); end
        n_checks++; if (wb_wreg !== 1'b0) begin n_fail++; $display("FAIL reset_wb_wreg: got %b want 0", wb_wreg); end
        n_checks++; if (wb_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wb_wdata: got %h want 0", wb_wdata); end
        n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL reset_align_err: got %b want 0", align_err); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_nonmem();
        mem_op    = 4'd0;
        mem_wd    = 5'd5;
        mem_wreg  = 1'b1;
        mem_wdata = 32'h1234;
        #1;
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL nonmem_stall: got %b want 0", stall_req); end
        tick();
        n_checks++; if (wb_wd !== 5'd5) begin n_fail++; $display("FAIL nonmem_wd: got %0d want 5", wb_wd); end
        n_checks++; if (wb_wreg !== 1'b1) begin n_fail++; $display("FAIL nonmem_wreg: got %b want 1", wb_wreg); end
        n_checks++; if (wb_wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL nonmem_wdata: got %h want 00001234", wb_wdata); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL nonmem_bus_req: got %b want 0", bus_req); end
        idle_inputs();
        tick();
        n_checks++; if (wb_wreg !== 1'b0) begin n_fail++; $display("FAIL nonmem_bubble_wreg: got %b want 0", wb_wreg); end
    endtask

    task automatic test_load_byte();
        int stall_cycles;
        stall_cycles = 0;
        mem_op    = 4'd1;
        mem_addr  = 32'h101;
        mem_wd    = 5'd7;
        mem_wreg  = 1'b1;
        bus_rdata = 32'h11F2_3344;
        #1;
        if (stall_req) stall_cycles++;
        tick();
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL lb_bus_req: got %b want 1", bus_req); end
        n_checks++; if (bus_sel !== 4'b0100) begin n_fail++; $display("FAIL lb_bus_sel: got %b want 0100", bus_sel); end
        n_checks++; if (bus_addr !== 32'h100) begin n_fail++; $display("FAIL lb_bus_addr: got %h want 00000100", bus_addr); end
        n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL lb_bus_we: got %b want 0", bus_we); end
        if (stall_req) stall_cycles++;
        tick();
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL lb_req_held: got %b want 1", bus_req); end
        if (stall_req) stall_cycles++;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL lb_req_drop: got %b want 0", bus_req); end
        if (stall_req) stall_cycles++;
        n_checks++; if (stall_cycles != 3) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d want 3", stall_cycles); end
        tick();
        idle_inputs();
        n_checks++; if (wb_wd !== 5'd7) begin n_fail++; $display("FAIL lb_wb_wd: got %0d want 7", wb_wd); end
        n_checks++; if (wb_wreg !== 1'b1) begin n_fail++; $display("FAIL lb_wb_wreg: got %b want 1", wb_wreg); end
        n_checks++; if (wb_wdata !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL lb_wb_wdata: got %h want fffffff2", wb_wdata); end
        tick();
    endtask

    task automatic test_store_half();
        mem_op    = 4'd7;
        mem_addr  = 32'h202;
        mem_sdata = 32'h0000_ABCD;
        mem_wd    = 5'd4;
        mem_wreg  = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL sh_stall: got %b want 1", stall_req); end
        tick();
        n_checks++; if (bus_we !== 1'b1) begin n_fail++; $display("FAIL sh_bus_we: got %b want 1", bus_we); end
        n_checks++; if (bus_sel !== 4'b0011) begin n_fail++; $display("FAIL sh_bus_sel: got %b want 0011", bus_sel); end
        n_checks++; if (bus_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_bus_wdata: got %h want abcdabcd", bus_wdata); end
        n_checks++; if (bus_addr !== 32'h200) begin n_fail++; $display("FAIL sh_bus_addr: got %h want 00000200", bus_addr); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL sh_done_stall: got %b want 0", stall_req); end
        tick();
        idle_inputs();
        n_checks++; if (wb_wreg !== 1'b0) begin n_fail++; $display("FAIL sh_wb_wreg: got %b want 0", wb_wreg); end
        tick();
    endtask

    task automatic test_misaligned();
        mem_op   = 4'd5;
        mem_addr = 32'h3;
        mem_wd   = 5'd6;
        mem_wreg = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL lw_mis_stall: got %b want 0", stall_req); end
        tick();
        n_checks++; if (align_err !== 1'b1) begin n_fail++; $display("FAIL lw_mis_align_err: got %b want 1", align_err); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL lw_mis_bus_req: got %b want 0", bus_req); end
        n_checks++; if (wb_wreg !== 1'b0) begin n_fail++; $display("FAIL lw_mis_wb_wreg: got %b want 0", wb_wreg); end
        idle_inputs();
        tick();
        n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL lw_mis_pulse_end: got %b want 0", align_err); end
        mem_op   = 4'd7;
        mem_addr = 32'h201;
        mem_wreg = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL sh_mis_stall: got %b want 0", stall_req); end
        tick();
        n_checks++; if (align_err !== 1'b1) begin n_fail++; $display("FAIL sh_mis_align_err: got %b want 1", align_err); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_idle();
        mem_op   = 4'd5;
        mem_addr = 32'h10;
        mem_wreg = 1'b1;
        mem_wd   = 5'd2;
        flush    = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b want 0", stall_req); end
        tick();
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_bus_req: got %b want 0", bus_req); end
        n_checks++; if (wb_wreg !== 1'b0) begin n_fail++; $display("FAIL flush_idle_wb_wreg: got %b want 0", wb_wreg); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_drain();
        mem_op   = 4'd5;
        mem_addr = 32'h40;
        mem_wd   = 5'd8;
        mem_wreg = 1'b1;
        tick();
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL drain_issue_req: got %b want 1", bus_req); end
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        mem_op    = 4'd0;
        mem_wd    = 5'd3;
        mem_wreg  = 1'b1;
        mem_wdata = 32'h77;
        #1;
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL drain_stall: got %b want 0", stall_req); end
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL drain_req_held[%0d]: got %b want 1", c, bus_req); end
            n_checks++; if (wb_wreg !== 1'b0) begin n_fail++; $display("FAIL drain_wb_wreg[%0d]: got %b want 0", c, wb_wreg); end
            tick();
        end
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL drain_req_before_ack: got %b want 1", bus_req); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL drain_req_drop: got %b want 0", bus_req); end
        n_checks++; if (wb_wreg !== 1'b0) begin n_fail++; $display("FAIL drain_ack_wb_wreg: got %b want 0", wb_wreg); end
        tick();
        n_checks++; if (wb_wreg !== 1'b1) begin n_fail++; $display("FAIL drain_back_idle_wreg: got %b want 1", wb_wreg); end
        n_checks++; if (wb_wd !== 5'd3) begin n_fail++; $display("FAIL drain_back_idle_wd: got %0d want 3", wb_wd); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        mem_op   = 4'd5;
        mem_addr = 32'h80;
        mem_wreg = 1'b1;
        tick();
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: got %b want 1", bus_req); end
        rst = 1'b1;
        tick();
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_drop: got %b want 0", bus_req); end
        n_checks++; if (bus_sel !== 4'b0000) begin n_fail++; $display("FAIL rstmid_sel: got %b want 0000", bus_sel); end
        n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0", bus_addr); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", stall_req); end
        rst       = 1'b0;
        mem_op    = 4'd4;
        mem_addr  = 32'h0;
        mem_wd    = 5'd9;
        mem_wreg  = 1'b1;
        bus_rdata = 32'h8001_FFFF;
        #1;
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL lhu_stall: got %b want 1", stall_req); end
        tick();
        n_checks++; if (bus_sel !== 4'b1100) begin n_fail++; $display("FAIL lhu_sel: got %b want 1100", bus_sel); end
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL lhu_req: got %b want 1", bus_req); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        tick();
        idle_inputs();
        n_checks++; if (wb_wdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_wb_wdata: got %h want 00008001", wb_wdata); end
        n_checks++; if (wb_wreg !== 1'b1) begin n_fail++; $display("FAIL lhu_wb_wreg: got %b want 1", wb_wreg); end
        n_checks++; if (wb_wd !== 5'd9) begin n_fail++; $display("FAIL lhu_wb_wd: got %0d want 9", wb_wd); end
        tick();
    endtask

    // One access with an immediate ack; the next call follows on the write-back edge.
    task automatic test_access(input string name, input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] rdata,
                               input logic [3:0] exp_sel, input logic [31:0] exp_bus_wdata,
                               input logic [31:0] exp_wb_data, input logic exp_wreg);
        mem_op    = op;
        mem_addr  = addr;
        mem_sdata = sdata;
        mem_wd    = 5'd12;
        mem_wreg  = 1'b1;
        bus_rdata = rdata;
        #1;
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL %s_stall: got %b want 1", name, stall_req); end
        tick();
        n_checks++; if (bus_sel !== exp_sel) begin n_fail++; $display("FAIL %s_sel: got %b want %b", name, bus_sel, exp_sel); end
        n_checks++; if (bus_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL %s_addr: got %h want %h", name, bus_addr, {addr[31:2], 2'b00}); end
        if (op >= 4'd6) begin
            n_checks++; if (bus_wdata !== exp_bus_wdata) begin n_fail++; $display("FAIL %s_bus_wdata: got %h want %h", name, bus_wdata, exp_bus_wdata); end
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        tick();
        n_checks++; if (wb_wreg !== exp_wreg) begin n_fail++; $display("FAIL %s_wb_wreg: got %b want %b", name, wb_wreg, exp_wreg); end
        if (exp_wreg) begin
            n_checks++; if (wb_wdata !== exp_wb_data) begin n_fail++; $display("FAIL %s_wb_wdata: got %h want %h", name, wb_wdata, exp_wb_data); end
        end
    endtask

    task automatic test_back_to_back();
        test_access("lh",  4'd3, 32'h0000_0002, 32'h0, 32'h1234_8765, 4'b0011, 32'h0, 32'hFFFF_8765, 1'b1);
        test_access("lb",  4'd1, 32'h0000_0003, 32'h0, 32'h0000_0080, 4'b0001, 32'h0, 32'hFFFF_FF80, 1'b1);
        test_access("lbu", 4'd2, 32'h0000_0000, 32'h0, 32'h80FF_FFFF, 4'b1000, 32'h0, 32'h0000_0080, 1'b1);
        test_access("lw",  4'd5, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b1);
        test_access("sb",  4'd6, 32'h0000_0003, 32'h1234_565A, 32'h0, 4'b0001, 32'h5A5A_5A5A, 32'h0, 1'b0);
        test_access("sw",  4'd8, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_flush_idle();
        test_flush_drain();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
